// File: rtl/m_conv_3_pkg.sv
// Shared constants, state encoding and output-stage helper for the layer-3 3x3 convolution.
package m_conv_3_pkg;

    localparam int IN_DIM    = 13;
    localparam int K         = 3;
    localparam int OUT_DIM   = IN_DIM - K + 1;
    localparam int OUT_COUNT = OUT_DIM * OUT_DIM;
    localparam int PROD_W    = 17;
    localparam int SUM_W     = 21;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    // Clamp a shifted sum into the unsigned 8-bit result range (ReLU + saturation).
    function automatic logic [7:0] relu_sat(input logic signed [SUM_W-1:0] s);
        if (s < 0)
            return 8'd0;
        else if (s > 255)
            return 8'hFF;
        else
            return s[7:0];
    endfunction

endpackage

// File: rtl/m_line_buffer_13.sv
// Fixed-depth shift buffer: d_out is the sample accepted DEPTH enables ago.
import m_conv_3_pkg::*;

module m_line_buffer_13 #(
    parameter int DEPTH = IN_DIM,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out
);

    logic [DEPTH*WIDTH-1:0] shift_reg;

    always_ff @(posedge clk) begin
        if (en)
            shift_reg <= {shift_reg[(DEPTH-1)*WIDTH-1:0], d_in};
    end

    assign d_out = shift_reg[DEPTH*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/m_conv_3.sv
// Streaming 3x3 convolution over a 13x13 pooled frame, writing 121 ReLU/shift/saturated results.
import m_conv_3_pkg::*;

module m_conv_3 #(
    parameter logic signed [7:0]  W0    = 8'sd1,
    parameter logic signed [7:0]  W1    = 8'sd1,
    parameter logic signed [7:0]  W2    = 8'sd1,
    parameter logic signed [7:0]  W3    = 8'sd1,
    parameter logic signed [7:0]  W4    = 8'sd1,
    parameter logic signed [7:0]  W5    = 8'sd1,
    parameter logic signed [7:0]  W6    = 8'sd1,
    parameter logic signed [7:0]  W7    = 8'sd1,
    parameter logic signed [7:0]  W8    = 8'sd1,
    parameter logic signed [15:0] BIAS  = 16'sd0,
    parameter int                 SHIFT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_valid,
    input  logic [7:0] d_in,
    output logic       wr_en,
    output logic [6:0] wr_addr,
    output logic [7:0] d_out,
    output logic       layer_3_write_complete
);

    localparam logic signed [7:0] WEIGHTS [K*K] = '{W0, W1, W2, W3, W4, W5, W6, W7, W8};

    state_t     state_reg;
    logic [3:0] row_reg;
    logic [3:0] col_reg;
    logic       in_done_reg;
    logic [6:0] wr_count_reg;
    logic       win_valid_reg;
    logic       prod_valid_reg;
    logic       sum_valid_reg;

    logic                     accept;
    logic                     win_done;
    logic [7:0]               row0_tap;
    logic [7:0]               row1_tap;
    logic [7:0]               col_in [K];
    logic [7:0]               win_reg [K][K];
    logic signed [PROD_W-1:0] prod_next [K*K];
    logic signed [PROD_W-1:0] prod_reg [K*K];
    logic signed [SUM_W-1:0]  sum_next;
    logic signed [SUM_W-1:0]  sum_reg;
    logic signed [SUM_W-1:0]  shifted;

    assign accept   = data_valid && (state_reg == RUN) && !in_done_reg;
    assign win_done = accept && (row_reg >= 4'd2) && (col_reg >= 4'd2);

    m_line_buffer_13 u_line_1 (
        .clk   (clk),
        .en    (accept),
        .d_in  (d_in),
        .d_out (row1_tap)
    );

    m_line_buffer_13 u_line_0 (
        .clk   (clk),
        .en    (accept),
        .d_in  (row1_tap),
        .d_out (row0_tap)
    );

    // Window row 0 is the oldest image row; column 2 holds the newest sample.
    assign col_in[0] = row0_tap;
    assign col_in[1] = row1_tap;
    assign col_in[2] = d_in;

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < K; r++) begin
                win_reg[r][0] <= win_reg[r][1];
                win_reg[r][1] <= win_reg[r][2];
                win_reg[r][2] <= col_in[r];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < K*K; gi++) begin : g_prod
            assign prod_next[gi] = $signed({1'b0, win_reg[gi / K][gi % K]}) * WEIGHTS[gi];
        end
    endgenerate

    always_comb begin
        sum_next = {{(SUM_W-16){BIAS[15]}}, BIAS};
        for (int i = 0; i < K*K; i++)
            sum_next = sum_next + {{(SUM_W-PROD_W){prod_reg[i][PROD_W-1]}}, prod_reg[i]};
    end

    assign shifted = sum_reg >>> SHIFT;

    always_ff @(posedge clk) begin
        prod_reg <= prod_next;
        sum_reg  <= sum_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg              <= RUN;
            row_reg                <= 4'd0;
            col_reg                <= 4'd0;
            in_done_reg            <= 1'b0;
            wr_count_reg           <= 7'd0;
            win_valid_reg          <= 1'b0;
            prod_valid_reg         <= 1'b0;
            sum_valid_reg          <= 1'b0;
            wr_en                  <= 1'b0;
            wr_addr                <= 7'd0;
            d_out                  <= 8'd0;
            layer_3_write_complete <= 1'b0;
        end else begin
            if (accept) begin
                if (col_reg == 4'(IN_DIM-1)) begin
                    col_reg <= 4'd0;
                    if (row_reg == 4'(IN_DIM-1))
                        in_done_reg <= 1'b1;
                    else
                        row_reg <= row_reg + 4'd1;
                end else begin
                    col_reg <= col_reg + 4'd1;
                end
            end

            win_valid_reg  <= win_done;
            prod_valid_reg <= win_valid_reg;
            sum_valid_reg  <= prod_valid_reg;
            wr_en          <= sum_valid_reg;

            if (sum_valid_reg) begin
                d_out        <= relu_sat(shifted);
                wr_addr      <= wr_count_reg;
                wr_count_reg <= wr_count_reg + 7'd1;
            end

            // The final write of the frame retires the block until the next reset.
            if (wr_en && (wr_addr == 7'(OUT_COUNT-1))) begin
                state_reg              <= DONE;
                layer_3_write_complete <= 1'b1;
            end
        end
    end

endmodule
